// File: rtl/stack_ctrl_pipe.sv
// Multi-cycle control unit for a stack machine: FETCH/DECODE sequencer, stack depth tracking and sticky fault/halt status.
// Optional macro STACK_GUARD_EN enables underflow/overflow depth checks in DECODE.
module stack_ctrl_pipe #(
  parameter int SP_W = 4,
  parameter int OPW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           IR_write,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           pc_src,
  output logic           ld_A,
  output logic           ld_B,
  output logic           src_A,
  output logic           src_B,
  output logic           IorD,
  output logic           mem_read,
  output logic           mem_write,
  output logic           push,
  output logic           pop,
  output logic           tos,
  output logic           MtoS,
  output logic           dup,
  output logic [1:0]     alu_op,
  output logic [SP_W:0]  stack_depth,
  output logic           fault,
  output logic           halted,
  output logic [1:0]     fault_code
);

  if (OPW < 4) begin : g_opw_check
    $error("stack_ctrl_pipe: OPW must be at least 4");
  end

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_JMP, S_JZ, S_PUSH_RD, S_PUSH_WR, S_POP1, S_LD1,
    S_POP_ST, S_POP2, S_LD2, S_ALU_BIN, S_ALU_NOT, S_PUSH_RES, S_DUP,
    S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_DUP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t          state_reg, state_next;
  logic [SP_W:0]   depth_reg, depth_next;
  logic            fault_reg, halted_reg;
  logic [1:0]      fault_code_reg;
  logic [3:0]      op_lo;
  logic            upper_nz;
  logic            illegal;
  logic [1:0]      guard_code;

  assign op_lo    = opcode[3:0];
  assign upper_nz = (opcode >> 4) != '0;

  always_comb begin
    illegal = 1'b0;
    case (op_lo)
      OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_PUSH,
      OP_POP, OP_JMP, OP_JZ, OP_DUP, OP_HALT: illegal = upper_nz;
      default:                                illegal = 1'b1;
    endcase
  end

`ifdef STACK_GUARD_EN
  localparam logic [SP_W:0] CAP = {1'b1, {SP_W{1'b0}}};

  // Underflow is tested before overflow so an empty-stack DUP reports 01.
  always_comb begin
    guard_code = 2'b00;
    if (illegal) begin
      guard_code = 2'b11;
    end else begin
      case (op_lo)
        OP_ADD, OP_SUB, OP_AND: if (depth_reg < (SP_W+1)'(2)) guard_code = 2'b01;
        OP_NOT, OP_POP, OP_JZ:  if (depth_reg == '0) guard_code = 2'b01;
        OP_DUP: begin
          if (depth_reg == '0)       guard_code = 2'b01;
          else if (depth_reg == CAP) guard_code = 2'b10;
        end
        OP_PUSH: if (depth_reg == CAP) guard_code = 2'b10;
        default: guard_code = 2'b00;
      endcase
    end
  end
`else
  assign guard_code = illegal ? 2'b11 : 2'b00;
`endif

  always_comb begin
    state_next    = state_reg;
    IR_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    ld_A          = 1'b0;
    ld_B          = 1'b0;
    src_A         = 1'b0;
    src_B         = 1'b0;
    IorD          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    tos           = 1'b0;
    MtoS          = 1'b0;
    dup           = 1'b0;
    alu_op        = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        src_A    = 1'b1;
        src_B    = 1'b1;
        if (mem_ready) begin
          IR_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        tos = 1'b1;
        if (guard_code != 2'b00) begin
          state_next = S_FAULT;
        end else begin
          case (op_lo)
            OP_JMP:  state_next = S_JMP;
            OP_JZ:   state_next = S_JZ;
            OP_PUSH: state_next = S_PUSH_RD;
            OP_DUP:  state_next = S_DUP;
            OP_HALT: state_next = S_HALT;
            default: state_next = S_POP1;
          endcase
        end
      end
      S_JMP: begin
        pc_src     = 1'b1;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_JZ: begin
        pc_src        = 1'b1;
        pc_write_cond = 1'b1;
        state_next    = S_FETCH;
      end
      S_PUSH_RD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_next = S_PUSH_WR;
      end
      S_PUSH_WR: begin
        MtoS       = 1'b1;
        push       = 1'b1;
        state_next = S_FETCH;
      end
      S_POP1: begin
        pop        = 1'b1;
        state_next = S_LD1;
      end
      S_LD1: begin
        ld_A = 1'b1;
        case (op_lo)
          OP_NOT:  state_next = S_ALU_NOT;
          OP_POP:  state_next = S_POP_ST;
          default: state_next = S_POP2;
        endcase
      end
      S_POP_ST: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_POP2: begin
        pop        = 1'b1;
        state_next = S_LD2;
      end
      S_LD2: begin
        ld_B       = 1'b1;
        state_next = S_ALU_BIN;
      end
      S_ALU_BIN: begin
        alu_op     = op_lo[1:0];
        state_next = S_PUSH_RES;
      end
      S_ALU_NOT: begin
        alu_op     = 2'b11;
        state_next = S_PUSH_RES;
      end
      S_PUSH_RES: begin
        push       = 1'b1;
        state_next = S_FETCH;
      end
      S_DUP: begin
        dup        = 1'b1;
        push       = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  // Without guards the counter is allowed to wrap modulo 2**(SP_W+1).
  always_comb begin
    depth_next = depth_reg;
    if (push)     depth_next = depth_reg + (SP_W+1)'(1);
    else if (pop) depth_next = depth_reg - (SP_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      depth_reg      <= '0;
      fault_reg      <= 1'b0;
      fault_code_reg <= 2'b00;
      halted_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      depth_reg <= depth_next;
      if (state_reg == S_DECODE && guard_code != 2'b00) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= guard_code;
      end
      if (state_next == S_HALT) halted_reg <= 1'b1;
    end
  end

  assign stack_depth = depth_reg;
  assign fault       = fault_reg;
  assign fault_code  = fault_code_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_stack_ctrl_pipe.sv
// Self-checking bench for stack_ctrl_pipe: directed scenarios plus random instruction streams
// compared cycle by cycle against an instruction-level reference model (honours STACK_GUARD_EN).
module tb_stack_ctrl_pipe;
  localparam int SP_W = 2;
  localparam int OPW  = 4;
  localparam int CAP  = 1 << SP_W;
  localparam int MODW = 2 * CAP;

  // Observed vector layout: fault, fault_code[1:0], halted, alu_op[1:0], then 16 strobes.
  localparam logic [21:0] M_DUP  = 22'h1 << 0;
  localparam logic [21:0] M_MTOS = 22'h1 << 1;
  localparam logic [21:0] M_TOS  = 22'h1 << 2;
  localparam logic [21:0] M_POP  = 22'h1 << 3;
  localparam logic [21:0] M_PUSH = 22'h1 << 4;
  localparam logic [21:0] M_WR   = 22'h1 << 5;
  localparam logic [21:0] M_RD   = 22'h1 << 6;
  localparam logic [21:0] M_IORD = 22'h1 << 7;
  localparam logic [21:0] M_SB   = 22'h1 << 8;
  localparam logic [21:0] M_SA   = 22'h1 << 9;
  localparam logic [21:0] M_LDB  = 22'h1 << 10;
  localparam logic [21:0] M_LDA  = 22'h1 << 11;
  localparam logic [21:0] M_PCS  = 22'h1 << 12;
  localparam logic [21:0] M_PCC  = 22'h1 << 13;
  localparam logic [21:0] M_PCW  = 22'h1 << 14;
  localparam logic [21:0] M_IRW  = 22'h1 << 15;
  localparam logic [21:0] M_HALT = 22'h1 << 18;
  localparam logic [21:0] M_FLT  = 22'h1 << 21;

  localparam logic [21:0] V_F    = M_RD | M_SA | M_SB;
  localparam logic [21:0] V_FD   = V_F | M_IRW | M_PCW;
  localparam logic [21:0] V_DEC  = M_TOS;
  localparam logic [21:0] V_JMP  = M_PCS | M_PCW;
  localparam logic [21:0] V_JZ   = M_PCS | M_PCC;
  localparam logic [21:0] V_PRD  = M_IORD | M_RD;
  localparam logic [21:0] V_PWR  = M_MTOS | M_PUSH;
  localparam logic [21:0] V_PST  = M_IORD | M_WR;
  localparam logic [21:0] V_NOT  = 22'h3 << 16;
  localparam logic [21:0] V_DUP  = M_DUP | M_PUSH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic IR_write, pc_write, pc_write_cond, pc_src, ld_A, ld_B, src_A, src_B;
  logic IorD, mem_read, mem_write, push, pop, tos, MtoS, dup;
  logic [1:0] alu_op, fault_code;
  logic [SP_W:0] stack_depth;
  logic fault, halted;
  logic [21:0] obs;

  int tests = 0;
  int fails = 0;
  int md = 0;
  bit term = 1'b0;

  stack_ctrl_pipe #(.SP_W(SP_W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .IR_write(IR_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .ld_A(ld_A), .ld_B(ld_B), .src_A(src_A), .src_B(src_B),
    .IorD(IorD), .mem_read(mem_read), .mem_write(mem_write),
    .push(push), .pop(pop), .tos(tos), .MtoS(MtoS), .dup(dup),
    .alu_op(alu_op), .stack_depth(stack_depth),
    .fault(fault), .halted(halted), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  assign obs = {fault, fault_code, halted, alu_op, IR_write, pc_write, pc_write_cond, pc_src,
                ld_A, ld_B, src_A, src_B, IorD, mem_read, mem_write, push, pop, tos, MtoS, dup};

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fault code the machine must report for opcode op at stack depth d.
  function automatic logic [1:0] expect_fault(input logic [3:0] op, input int d);
    if (!(op <= 4'd8 || op == 4'd15)) return 2'b11;
`ifdef STACK_GUARD_EN
    case (op)
      4'd0, 4'd1, 4'd2: if (d < 2) return 2'b01;
      4'd3, 4'd5, 4'd7: if (d < 1) return 2'b01;
      4'd8: begin
        if (d < 1) return 2'b01;
        if (d >= CAP) return 2'b10;
      end
      4'd4: if (d >= CAP) return 2'b10;
      default: ;
    endcase
`endif
    return 2'b00;
  endfunction

  task automatic step(input logic mr, input logic [21:0] exp, input string tag);
    @(negedge clk);
    mem_ready = mr;
    #1;
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_depth(input string tag);
    logic [SP_W:0] exp;
    exp = (SP_W+1)'(md);
    tests++;
    assert (stack_depth === exp) else begin
      fails++;
      $error("FAIL %s: observed depth %0d expected %0d", tag, stack_depth, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rnd();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    md = 0;
    term = 1'b0;
    tests++;
    assert (obs === V_F) else begin
      fails++;
      $error("FAIL reset_state: observed %h expected %h", obs, V_F);
    end
    check_depth("reset_depth");
    rst = 1'b1;
  endtask

  // Runs one instruction from its first FETCH cycle to its completion (or terminal state).
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
    logic [1:0] fc;
    $display("[TB] instr op=%h depth=%0d fetch_wait=%0d mem_wait=%0d", op, md, fw, mw);
    opcode = op;
    for (int i = 0; i <= fw; i++) begin
      step(i == fw, (i == fw) ? V_FD : V_F, "fetch");
      if (i == 0) check_depth("depth_at_fetch");
    end
    step(rnd(), V_DEC, "decode");
    fc = expect_fault(op, md);
    if (fc != 2'b00) begin
      repeat (2) begin
        step(rnd(), M_FLT | (22'(fc) << 19), "fault");
        check_depth("depth_in_fault");
      end
      term = 1'b1;
      return;
    end
    case (op)
      4'd6: step(rnd(), V_JMP, "jmp");
      4'd7: step(rnd(), V_JZ, "jz");
      4'd4: begin
        for (int i = 0; i < mw; i++) step(1'b0, V_PRD, "push_rd_wait");
        step(1'b1, V_PRD, "push_rd");
        step(rnd(), V_PWR, "push_wr");
        md = (md + 1) % MODW;
      end
      4'd8: begin
        step(rnd(), V_DUP, "dup");
        md = (md + 1) % MODW;
      end
      4'd15: begin
        repeat (2) step(rnd(), M_HALT, "halt");
        term = 1'b1;
      end
      4'd3: begin
        step(rnd(), M_POP, "pop1");
        step(rnd(), M_LDA, "ld1");
        step(rnd(), V_NOT, "alu_not");
        step(rnd(), M_PUSH, "push_res");
      end
      4'd5: begin
        step(rnd(), M_POP, "pop1");
        step(rnd(), M_LDA, "ld1");
        for (int i = 0; i < mw; i++) step(1'b0, V_PST, "pop_st_wait");
        step(1'b1, V_PST, "pop_st");
        md = (md + MODW - 1) % MODW;
      end
      default: begin
        step(rnd(), M_POP, "pop1");
        step(rnd(), M_LDA, "ld1");
        step(rnd(), M_POP, "pop2");
        step(rnd(), M_LDB, "ld2");
        step(rnd(), 22'(op[1:0]) << 16, "alu_bin");
        step(rnd(), M_PUSH, "push_res");
        md = (md + MODW - 1) % MODW;
      end
    endcase
  endtask

  initial begin
    logic [3:0] op;
    int r;
    do_reset();
    // Delayed memory on fetch and operand read, then a two-operand SUB.
    run_instr(4'd4, 3, 3);
    run_instr(4'd4, 0, 1);
    run_instr(4'd1, 1, 0);
    run_instr(4'd8, 0, 0);
    run_instr(4'd0, 0, 0);
    run_instr(4'd3, 2, 0);
    run_instr(4'd7, 0, 0);
    run_instr(4'd6, 0, 0);
    run_instr(4'd5, 0, 2);
    if (term) do_reset();
    // ADD on a one-entry stack.
    do_reset();
    run_instr(4'd4, 0, 0);
    run_instr(4'd0, 0, 0);
    if (term) do_reset();
    // Fill beyond capacity.
    do_reset();
    for (int i = 0; i <= CAP && !term; i++) run_instr(4'd4, 0, 0);
    if (term) do_reset();
    // Reset while PUSH_RD is waiting on memory.
    opcode = 4'd4;
    step(1'b1, V_FD, "fetch");
    step(1'b0, V_DEC, "decode");
    step(1'b0, V_PRD, "push_rd_wait");
    step(1'b0, V_PRD, "push_rd_wait");
    do_reset();
    run_instr(4'hA, 0, 0);
    do_reset();
    run_instr(4'hF, 1, 0);
    do_reset();
    run_instr(4'd4, 0, 0);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)      op = 4'(9 + $urandom_range(0, 5));
      else if (r < 5) op = 4'hF;
      else            op = 4'($urandom_range(0, 8));
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      if (term) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
